// File: rtl/tour_sequencer_if.sv
// tour_sequencer_if: bundles the move-store, command-processor and BLE
// response signals around the tour sequencer. The master modport is the
// sequencer itself; the slave modport is the surrounding system.
interface tour_sequencer_if #(
  parameter int INDX_W = 5
) ();
  logic              start_tour;
  logic [7:0]        move;
  logic [INDX_W-1:0] mv_indx;
  logic [15:0]       cmd_UART;
  logic              cmd_rdy_UART;
  logic              clr_cmd_rdy;
  logic              send_resp;
  logic [15:0]       cmd;
  logic              cmd_rdy;
  logic [7:0]        resp;
  logic              usurp;

  modport master (
    input  start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    output mv_indx, cmd, cmd_rdy, resp, usurp
  );

  modport slave (
    output start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    input  mv_indx, cmd, cmd_rdy, resp, usurp
  );
endinterface

// File: rtl/tour_sequencer.sv
// tour_sequencer: turns a solved Knight's Tour (one-hot moves read from the
// move store) into pairs of MOVE commands (vertical leg, then horizontal leg
// with fanfare), taking over the command processor input while a tour runs.
// Optional feature macro: TOUR_ABORT_EN adds an 'abort' input that returns
// the sequencer to IDLE from any active state.
module tour_sequencer #(
  parameter int NUM_MOVES = 24,
  parameter int INDX_W    = 5
) (
  input logic clk,
  input logic rst,
`ifdef TOUR_ABORT_EN
  input logic abort,
`endif
  tour_sequencer_if.master bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] VERT   = 3'd1;
  localparam logic [2:0] WAIT_V = 3'd2;
  localparam logic [2:0] HORZ   = 3'd3;
  localparam logic [2:0] WAIT_H = 3'd4;
  localparam logic [2:0] LOAD   = 3'd5;

  localparam logic [INDX_W-1:0] LAST = INDX_W'(NUM_MOVES - 1);

  logic [2:0]        state_q, state_d;
  logic [INDX_W-1:0] mv_indx_q, mv_indx_d;
  logic              usurp_q, usurp_d;
  logic [15:0]       cmd_q, cmd_d;
  logic              cmd_rdy_q, cmd_rdy_d;

  logic [2:0]  sel;
  logic [7:0]  vhead, hhead;
  logic [3:0]  vcnt, hcnt;
  logic [15:0] vert_cmd, horz_cmd;

  // Lowest set move bit wins; an all-zero move falls through to bit 7.
  always_comb begin
    sel = 3'd7;
    for (int unsigned i = 0; i < 8; i++) begin
      if (bus.move[7 - i]) sel = 3'(7 - i);
    end
  end

  // Leg headings/counts for each knight move direction.
  always_comb begin
    vhead = 8'h00; vcnt = 4'd1; hhead = 8'hBF; hcnt = 4'd2;
    case (sel)
      3'd0: begin vhead = 8'h00; vcnt = 4'd2; hhead = 8'h3F; hcnt = 4'd1; end
      3'd1: begin vhead = 8'h00; vcnt = 4'd2; hhead = 8'hBF; hcnt = 4'd1; end
      3'd2: begin vhead = 8'h00; vcnt = 4'd1; hhead = 8'h3F; hcnt = 4'd2; end
      3'd3: begin vhead = 8'h7F; vcnt = 4'd1; hhead = 8'h3F; hcnt = 4'd2; end
      3'd4: begin vhead = 8'h7F; vcnt = 4'd2; hhead = 8'h3F; hcnt = 4'd1; end
      3'd5: begin vhead = 8'h7F; vcnt = 4'd2; hhead = 8'hBF; hcnt = 4'd1; end
      3'd6: begin vhead = 8'h7F; vcnt = 4'd1; hhead = 8'hBF; hcnt = 4'd2; end
      default: begin vhead = 8'h00; vcnt = 4'd1; hhead = 8'hBF; hcnt = 4'd2; end
    endcase
    vert_cmd = {4'b0010, vhead, vcnt};
    horz_cmd = {4'b0011, hhead, hcnt};
  end

  // Next-state logic for the handshake FSM. WAIT_H hops through LOAD so the
  // next vertical command is decoded from the move at the updated index.
  always_comb begin
    state_d   = state_q;
    mv_indx_d = mv_indx_q;
    usurp_d   = usurp_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q;
    case (state_q)
      IDLE: if (bus.start_tour) begin
        mv_indx_d = '0;
        usurp_d   = 1'b1;
        cmd_d     = vert_cmd;
        cmd_rdy_d = 1'b1;
        state_d   = VERT;
      end
      VERT: if (bus.clr_cmd_rdy) begin
        cmd_rdy_d = 1'b0;
        state_d   = WAIT_V;
      end
      WAIT_V: if (bus.send_resp) begin
        cmd_d     = horz_cmd;
        cmd_rdy_d = 1'b1;
        state_d   = HORZ;
      end
      HORZ: if (bus.clr_cmd_rdy) begin
        cmd_rdy_d = 1'b0;
        state_d   = WAIT_H;
      end
      WAIT_H: if (bus.send_resp) begin
        if (mv_indx_q == LAST) begin
          usurp_d   = 1'b0;
          mv_indx_d = '0;
          state_d   = IDLE;
        end else begin
          mv_indx_d = mv_indx_q + INDX_W'(1);
          state_d   = LOAD;
        end
      end
      LOAD: begin
        cmd_d     = vert_cmd;
        cmd_rdy_d = 1'b1;
        state_d   = VERT;
      end
      default: state_d = IDLE;
    endcase
`ifdef TOUR_ABORT_EN
    if (abort && (state_q != IDLE)) begin
      state_d   = IDLE;
      cmd_rdy_d = 1'b0;
      usurp_d   = 1'b0;
      mv_indx_d = '0;
    end
`endif
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mv_indx_q <= '0;
      usurp_q   <= 1'b0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mv_indx_q <= mv_indx_d;
      usurp_q   <= usurp_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
    end
  end

  // Command mux and BLE response; final WAIT_H reports completion (A5).
  always_comb begin
    bus.mv_indx = mv_indx_q;
    bus.usurp   = usurp_q;
    bus.cmd     = usurp_q ? cmd_q : bus.cmd_UART;
    bus.cmd_rdy = usurp_q ? cmd_rdy_q : bus.cmd_rdy_UART;
    if (usurp_q && !((state_q == WAIT_H) && (mv_indx_q == LAST)))
      bus.resp = 8'h5A;
    else
      bus.resp = 8'hA5;
  end

endmodule

// File: tb/tb_tour_sequencer.sv
// tb_tour_sequencer: directed checks of the tour sequencer handshake, move
// decode, full-tour completion, reset and (when built with TOUR_ABORT_EN)
// abort behaviour.
module tb_tour_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef TOUR_ABORT_EN
  logic abort = 1'b0;
`endif
  int ntests = 0;
  int nfail  = 0;
  int ncmds  = 0;

  logic [7:0]  store [24];
  logic [7:0]  mv_tab [24];
  int          bit_tab [24];
  logic [15:0] vtab [8];
  logic [15:0] htab [8];

  tour_sequencer_if bus ();

  tour_sequencer dut (
    .clk (clk),
    .rst (rst),
`ifdef TOUR_ABORT_EN
    .abort (abort),
`endif
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.move = store[bus.mv_indx];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_clr();
    bus.clr_cmd_rdy = 1'b1; tick(); bus.clr_cmd_rdy = 1'b0;
  endtask

  task automatic pulse_send();
    bus.send_resp = 1'b1; tick(); bus.send_resp = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start_tour = 1'b1; tick(); bus.start_tour = 1'b0;
  endtask

  // Responder for one knight move: waits (bounded) for the vertical command,
  // acknowledges both legs and checks commands and responses along the way.
  task automatic run_move(input int i);
    for (int c = 0; c < 8 && bus.cmd_rdy !== 1'b1; c++) tick();
    chk($sformatf("wait_vert[%0d]", i), {15'd0, bus.cmd_rdy}, 16'd1);
    if (bus.cmd_rdy === 1'b1) ncmds++;
    chk($sformatf("vert[%0d]", i), bus.cmd, vtab[bit_tab[i]]);
    chk($sformatf("indx[%0d]", i), {11'd0, bus.mv_indx}, 16'(i));
    pulse_clr();
    pulse_send();
    chk($sformatf("horz_rdy[%0d]", i), {15'd0, bus.cmd_rdy}, 16'd1);
    if (bus.cmd_rdy === 1'b1) ncmds++;
    chk($sformatf("horz[%0d]", i), bus.cmd, htab[bit_tab[i]]);
    pulse_clr();
    chk($sformatf("resp_wh[%0d]", i), {8'd0, bus.resp}, (i == 23) ? 16'h00A5 : 16'h005A);
    pulse_send();
  endtask

  initial begin
    vtab = '{16'h2002, 16'h2002, 16'h2001, 16'h27F1, 16'h27F2, 16'h27F2, 16'h27F1, 16'h2001};
    htab = '{16'h33F1, 16'h3BF1, 16'h33F2, 16'h33F2, 16'h33F1, 16'h3BF1, 16'h3BF2, 16'h3BF2};
    mv_tab  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                8'h00, 8'h03, 8'h0C, 8'h30, 8'h60, 8'hC0, 8'hFF, 8'h06,
                8'h18, 8'hA0, 8'h48, 8'h90, 8'hE0, 8'h82, 8'h44, 8'h80};
    bit_tab = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 0, 2, 4, 5, 6, 0, 1,
                3, 5, 3, 4, 5, 1, 2, 7};
    for (int i = 0; i < 24; i++) store[i] = 8'h00;
    bus.start_tour   = 1'b0;
    bus.cmd_UART     = 16'h0000;
    bus.cmd_rdy_UART = 1'b1;
    bus.clr_cmd_rdy  = 1'b0;
    bus.send_resp    = 1'b0;

    // Reset and UART pass-through.
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_cmd", bus.cmd, 16'h0000);
    chk("rst_rdy", {15'd0, bus.cmd_rdy}, 16'd1);
    chk("rst_resp", {8'd0, bus.resp}, 16'h00A5);
    chk("rst_indx", {11'd0, bus.mv_indx}, 16'd0);
    chk("rst_usurp", {15'd0, bus.usurp}, 16'd0);
    bus.cmd_UART = 16'h1234;
    #1;
    chk("uart_pass", bus.cmd, 16'h1234);

    // Move 0 = bit0, move 1 = bit6.
    store[0] = 8'h01;
    store[1] = 8'h40;
    pulse_start();
    chk("t2_vert", bus.cmd, 16'h2002);
    chk("t2_rdy", {15'd0, bus.cmd_rdy}, 16'd1);
    chk("t2_usurp", {15'd0, bus.usurp}, 16'd1);
    chk("t2_resp", {8'd0, bus.resp}, 16'h005A);
    bus.cmd_rdy_UART = 1'b0;
    #1;
    chk("t2_mask0", {15'd0, bus.cmd_rdy}, 16'd1);
    bus.cmd_rdy_UART = 1'b1;
    pulse_clr();
    chk("t2_wv_rdy", {15'd0, bus.cmd_rdy}, 16'd0);
    pulse_send();
    chk("t2_horz", bus.cmd, 16'h33F1);
    chk("t2_horz_rdy", {15'd0, bus.cmd_rdy}, 16'd1);
    pulse_clr();
    chk("t2_wh_resp", {8'd0, bus.resp}, 16'h005A);
    pulse_send();
    chk("t3_indx", {11'd0, bus.mv_indx}, 16'd1);
    chk("t3_load_rdy", {15'd0, bus.cmd_rdy}, 16'd0);
    tick();
    chk("t3_vert_rdy", {15'd0, bus.cmd_rdy}, 16'd1);
    chk("t3_vert", bus.cmd, 16'h27F1);

    // start_tour mid-tour is ignored; clr+send together leaves WAIT_V pending.
    pulse_start();
    chk("t5_start_cmd", bus.cmd, 16'h27F1);
    chk("t5_start_indx", {11'd0, bus.mv_indx}, 16'd1);
    bus.clr_cmd_rdy = 1'b1; bus.send_resp = 1'b1;
    tick();
    bus.clr_cmd_rdy = 1'b0; bus.send_resp = 1'b0;
    chk("t5_both_rdy", {15'd0, bus.cmd_rdy}, 16'd0);
    tick(); tick();
    chk("t5_still_wait", {15'd0, bus.cmd_rdy}, 16'd0);
    pulse_send();
    chk("t5_horz", bus.cmd, 16'h3BF2);
    chk("t5_horz_rdy", {15'd0, bus.cmd_rdy}, 16'd1);

    // Full tour from a fresh reset.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    for (int i = 0; i < 24; i++) store[i] = mv_tab[i];
    pulse_start();
    for (int i = 0; i < 24; i++) run_move(i);
    chk("tour_ncmds", 16'(ncmds), 16'd48);
    chk("tour_usurp", {15'd0, bus.usurp}, 16'd0);
    chk("tour_indx", {11'd0, bus.mv_indx}, 16'd0);
    chk("tour_resp", {8'd0, bus.resp}, 16'h00A5);
    bus.cmd_UART = 16'hBEEF;
    #1;
    chk("tour_uart", bus.cmd, 16'hBEEF);

    // Asynchronous reset in WAIT_V of move 7.
    pulse_start();
    for (int i = 0; i < 7; i++) run_move(i);
    for (int c = 0; c < 8 && bus.cmd_rdy !== 1'b1; c++) tick();
    chk("t6_vert7", bus.cmd, vtab[bit_tab[7]]);
    pulse_clr();
    chk("t6_indx7", {11'd0, bus.mv_indx}, 16'd7);
    #2;
    bus.cmd_rdy_UART = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_usurp", {15'd0, bus.usurp}, 16'd0);
    chk("t6_rdy0", {15'd0, bus.cmd_rdy}, 16'd0);
    chk("t6_indx", {11'd0, bus.mv_indx}, 16'd0);
    chk("t6_resp", {8'd0, bus.resp}, 16'h00A5);
    bus.cmd_rdy_UART = 1'b1;
    #1;
    chk("t6_rdy1", {15'd0, bus.cmd_rdy}, 16'd1);
    tick();
    rst = 1'b0;
    tick();

`ifdef TOUR_ABORT_EN
    // Abort in HORZ beats a simultaneous clr_cmd_rdy.
    pulse_start();
    pulse_clr();
    pulse_send();
    chk("ab_horz", bus.cmd, htab[bit_tab[0]]);
    abort = 1'b1; bus.clr_cmd_rdy = 1'b1;
    tick();
    abort = 1'b0; bus.clr_cmd_rdy = 1'b0;
    bus.cmd_rdy_UART = 1'b0;
    #1;
    chk("ab_usurp", {15'd0, bus.usurp}, 16'd0);
    chk("ab_rdy", {15'd0, bus.cmd_rdy}, 16'd0);
    chk("ab_indx", {11'd0, bus.mv_indx}, 16'd0);
    chk("ab_resp", {8'd0, bus.resp}, 16'h00A5);
    bus.cmd_rdy_UART = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/tour_sequencer.md
Name: tour_sequencer

Overview:
Sequences a solved Knight's Tour into robot MOVE commands. It reads 24 one-hot knight moves from the move store. Each knight move becomes two MOVE commands: a vertical leg without fanfare, then a horizontal leg with fanfare. While a tour runs, the block takes over the command input of the command processor from the UART/BLE path. It also generates the per-move responses sent back over BLE.

Parameters:
NUM_MOVES, 24, number of knight moves in a full tour.
INDX_W, 5, width of the move index (must satisfy 2^INDX_W >= NUM_MOVES).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start_tour  in  1  one-cycle pulse from the tour solver; the solution is ready
move  in  8  one-hot knight move at index mv_indx (combinational read from move store)
mv_indx  out  INDX_W  index of the current move
cmd_UART  in  16  command from the UART/BLE receiver
cmd_rdy_UART  in  1  UART command valid
clr_cmd_rdy  in  1  one-cycle pulse from the command processor; command accepted
send_resp  in  1  one-cycle pulse from the command processor; command execution finished
cmd  out  16  muxed command to the command processor
cmd_rdy  out  1  muxed command valid
resp  out  8  response byte to the BLE transmitter
usurp  out  1  high while the tour owns cmd/cmd_rdy

Behaviour:
- Reset values: mv_indx=0, usurp=0, internal cmd_rdy=0, internal cmd=16'h0000, resp=8'hA5, state IDLE.
- Output mux:
  - usurp=0: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART.
  - usurp=1: cmd and cmd_rdy come from the internal registers.
- resp: 8'h5A while usurp=1, except 8'hA5 while state is WAIT_H and mv_indx==NUM_MOVES-1. Otherwise 8'hA5.
- Move decode (legs given as heading/count):
  - bit0: N/2, W/1
  - bit1: N/2, E/1
  - bit2: N/1, W/2
  - bit3: S/1, W/2
  - bit4: S/2, W/1
  - bit5: S/2, E/1
  - bit6: S/1, E/2
  - bit7: N/1, E/2
- Heading codes: N=8'h00, W=8'h3F, S=8'h7F, E=8'hBF.
- Priority: lowest set bit wins. move==0 decodes as bit7.
- Command format:
  - vertical = {4'b0010, heading, 4'(count)}
  - horizontal = {4'b0011, heading, 4'(count)}
- States:
  - IDLE: on start_tour, mv_indx<=0, usurp<=1, load vertical cmd, cmd_rdy<=1, go VERT. cmd/cmd_rdy are valid the cycle after the pulse.
  - VERT: hold cmd_rdy=1 until clr_cmd_rdy, then cmd_rdy<=0 and go WAIT_V.
  - WAIT_V: on send_resp, load horizontal cmd, cmd_rdy<=1, go HORZ.
  - HORZ: on clr_cmd_rdy, cmd_rdy<=0 and go WAIT_H.
  - WAIT_H: on send_resp:
    - if mv_indx==NUM_MOVES-1: usurp<=0, mv_indx<=0, go IDLE.
    - else: mv_indx<=mv_indx+1, load vertical cmd of the next move (decoded from move after the index update, so one cycle later), go VERT.
    - Implement WAIT_H→VERT through one transient LOAD state so decode always uses the updated index. cmd_rdy rises 2 cycles after send_resp.
- Simultaneous events:
  - clr_cmd_rdy and send_resp in the same cycle in VERT/HORZ: clr is honoured and send_resp is ignored.
  - send_resp outside WAIT_V/WAIT_H is ignored.
  - clr_cmd_rdy outside VERT/HORZ is ignored.
- start_tour outside IDLE is ignored.
- cmd_rdy_UART is ignored (masked) while usurp=1.
- Reset asserted mid-tour: immediate return to reset values; ownership goes back to UART asynchronously.

Optional Feature:
TOUR_ABORT_EN:
- Defined: adds input port abort (1 bit, pulse).
  - In any non-IDLE state, abort forces IDLE on the next edge: cmd_rdy<=0, usurp<=0, mv_indx<=0.
  - resp is 8'hA5 in that same next cycle.
  - abort beats a simultaneous clr_cmd_rdy, send_resp or start_tour.
- Undefined: no abort port; only rst ends a tour early.

Test Plan:
1. Reset, then usurp=0, cmd_UART=16'h0000, cmd_rdy_UART=1 -> cmd=16'h0000, cmd_rdy=1, resp=8'hA5, mv_indx=0.
2. start_tour with move[0]=8'h01 -> next cycle cmd=16'h2002, cmd_rdy=1, usurp=1; after clr+send_resp -> cmd=16'h33F1; resp=8'h5A.
3. move[0]=8'h40 -> vertical cmd=16'h27F1, horizontal cmd=16'h3BF2; after WAIT_H send_resp -> mv_indx=1 and next vertical cmd_rdy two cycles later.
4. Full 24-move tour with auto clr/send_resp responder -> 48 commands issued, resp=8'hA5 during the final WAIT_H, usurp=0 and mv_indx=0 afterwards.
5. clr_cmd_rdy and send_resp together in VERT -> state WAIT_V; a further send_resp is required before the horizontal cmd appears. start_tour mid-tour -> no effect.
6. rst asserted in WAIT_V (mv_indx=7) -> usurp=0, cmd_rdy follows cmd_rdy_UART, mv_indx=0 within the same cycle. With TOUR_ABORT_EN, abort in HORZ -> IDLE, usurp=0 next cycle.
